// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: combinational hit path, stalls the
// fetch stage on a miss and refills the whole line over a req/ack handshake.
module icache_responder #(
   parameter int          INDEX_W   = 4,
   parameter int          LINE_W    = 2,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   input  logic        Invalidate,
   output logic [31:0] InstrF,
   output logic        StallICache,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << LINE_W;
   localparam int TAG_W = 32 - INDEX_W - LINE_W - 2;
   localparam logic [LINE_W-1:0] LAST_WORD = '1;

   typedef enum logic {S_IDLE, S_REFILL} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [TAG_W-1:0]   r_tag_mem  [LINES];
   logic [31:0]        r_data_mem [LINES*WORDS];
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_refill_tag;
   logic [INDEX_W-1:0] r_refill_index;
   logic [LINE_W-1:0]  r_word_cnt;
   logic               r_inv_pending;

   logic [LINE_W-1:0]  w_offset;
   logic [INDEX_W-1:0] w_index;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic               w_ack_fire;
   logic               w_last_ack;
   logic               w_inv_at_end;
   logic               w_unused;

   assign w_offset = PCF[LINE_W+1:2];
   assign w_index  = PCF[LINE_W+INDEX_W+1:LINE_W+2];
   assign w_tag    = PCF[31:LINE_W+INDEX_W+2];
   assign w_unused = &{1'b0, PCF[1:0]};

   assign w_hit        = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
   assign w_ack_fire   = (r_state == S_REFILL) && mem_ack;
   assign w_last_ack   = w_ack_fire && (r_word_cnt == LAST_WORD);
   // An invalidate arriving on the very last ack must still suppress the line.
   assign w_inv_at_end = r_inv_pending || Invalidate;

   always_comb begin
      w_state_next = r_state;
      StallICache  = 1'b1;
      InstrF       = NOP_INSTR;
      mem_req      = 1'b0;
      mem_addr     = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               StallICache = 1'b0;
               InstrF      = r_data_mem[{w_index, w_offset}];
            end else begin
               w_state_next = S_REFILL;
            end
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {r_refill_tag, r_refill_index, r_word_cnt, 2'b00};
            if (w_last_ack) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_valid        <= '0;
         r_word_cnt     <= '0;
         r_inv_pending  <= 1'b0;
         r_refill_tag   <= '0;
         r_refill_index <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE) begin
            if (Invalidate) begin
               r_valid <= '0;
            end
            if (!w_hit) begin
               r_refill_tag   <= w_tag;
               r_refill_index <= w_index;
               r_word_cnt     <= '0;
            end
         end else begin
            if (Invalidate) begin
               r_inv_pending <= 1'b1;
            end
            if (w_ack_fire) begin
               r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_last_ack) begin
               r_inv_pending <= 1'b0;
               if (w_inv_at_end) begin
                  r_valid <= '0;
               end else begin
                  r_valid[r_refill_index] <= 1'b1;
               end
            end
         end
      end
   end

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (w_ack_fire) begin
         r_data_mem[{r_refill_index, r_word_cnt}] <= mem_rdata;
      end
      if (w_last_ack && !w_inv_at_end) begin
         r_tag_mem[r_refill_index] <= r_refill_tag;
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a small in-bench backing-memory responder.
module tb_icache_responder;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        Invalidate;
   logic [31:0] InstrF;
   logic        StallICache;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   icache_responder #(.INDEX_W(4), .LINE_W(2), .NOP_INSTR(NOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCF        (PCF),
      .Invalidate (Invalidate),
      .InstrF     (InstrF),
      .StallICache(StallICache),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("req_seen", {31'b0, mem_req}, 32'h1);
   endtask

   // PCF misses: stall immediately, NOP on InstrF, no request until the next edge.
   task automatic start_miss(input logic [31:0] pc);
      PCF = pc;
      #1;
      check_val("miss_stall", {31'b0, StallICache}, 32'h1);
      check_val("miss_instr", InstrF, NOP);
      check_val("miss_noreq", {31'b0, mem_req}, 32'h0);
      @(negedge clk);
   endtask

   task automatic expect_hit(input logic [31:0] pc, input logic [31:0] exp);
      PCF = pc;
      #1;
      check_val("hit_instr", InstrF, exp);
      check_val("hit_stall", {31'b0, StallICache}, 32'h0);
      check_val("hit_noreq", {31'b0, mem_req}, 32'h0);
      $display("hit pc=%08h instr=%08h", pc, InstrF);
      @(negedge clk);
   endtask

   // Serves nwords of a line refill, acking lat cycles after each request is seen.
   task automatic serve_refill(input logic [31:0] line, input logic [31:0] base,
                               input int lat, input int nwords, input int inv_word);
      for (int w = 0; w < nwords; w++) begin
         wait_req();
         for (int c = 0; c < lat; c++) begin
            check_val("addr_hold", mem_addr, line + 32'(w * 4));
            @(negedge clk);
         end
         check_val("refill_addr", mem_addr, line + 32'(w * 4));
         check_val("refill_stall", {31'b0, StallICache}, 32'h1);
         check_val("refill_instr", InstrF, NOP);
         mem_ack   = 1'b1;
         mem_rdata = base + 32'(w);
         if (w == inv_word) Invalidate = 1'b1;
         @(negedge clk);
         mem_ack    = 1'b0;
         Invalidate = 1'b0;
      end
      $display("refill line=%08h words=%0d base=%08h", line, nwords, base);
   endtask

   task automatic check_done();
      check_val("done_noreq", {31'b0, mem_req}, 32'h0);
      check_val("done_addr", mem_addr, 32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      PCF        = 32'h0;
      Invalidate = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      #1;
      check_val("rst_req", {31'b0, mem_req}, 32'h0);
      check_val("rst_addr", mem_addr, 32'h0);
      check_val("rst_stall", {31'b0, StallICache}, 32'h1);
      check_val("rst_instr", InstrF, NOP);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Cold miss with 3-cycle ack latency
      start_miss(32'h0);
      serve_refill(32'h0, 32'hA0, 3, 4, -1);
      check_done();
      expect_hit(32'h0, 32'hA0);
      expect_hit(32'h4, 32'hA1);
      expect_hit(32'h8, 32'hA2);
      expect_hit(32'hC, 32'hA3);

      // Conflict miss on index 0, then the original line refetched
      start_miss(32'h100);
      serve_refill(32'h100, 32'hB0, 0, 4, -1);
      check_done();
      expect_hit(32'h104, 32'hB1);
      start_miss(32'h0);
      serve_refill(32'h0, 32'hA0, 0, 4, -1);
      expect_hit(32'h0, 32'hA0);

      // Invalidate in IDLE: same-cycle lookup still hits, afterwards misses
      PCF        = 32'h0;
      Invalidate = 1'b1;
      #1;
      check_val("inv_same_cycle_stall", {31'b0, StallICache}, 32'h0);
      check_val("inv_same_cycle_instr", InstrF, 32'hA0);
      @(negedge clk);
      Invalidate = 1'b0;
      start_miss(32'h0);
      serve_refill(32'h0, 32'hC0, 1, 4, -1);
      expect_hit(32'h0, 32'hC0);

      // Invalidate during refill: refilled line stays invalid
      start_miss(32'h200);
      serve_refill(32'h200, 32'hD0, 0, 4, 1);
      check_done();
      start_miss(32'h200);
      serve_refill(32'h200, 32'hD0, 0, 4, -1);
      expect_hit(32'h200, 32'hD0);

      // Asynchronous reset after the second ack
      start_miss(32'h300);
      serve_refill(32'h300, 32'h11, 0, 2, -1);
      check_val("pre_rst_addr", mem_addr, 32'h308);
      #2 rst = 1'b1;
      #1;
      check_val("arst_req", {31'b0, mem_req}, 32'h0);
      check_val("arst_addr", mem_addr, 32'h0);
      check_val("arst_stall", {31'b0, StallICache}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      start_miss(32'h300);
      serve_refill(32'h300, 32'hE0, 2, 4, -1);
      expect_hit(32'h308, 32'hE2);
      expect_hit(32'h300, 32'hE0);

      // Ack held high across four words and one extra IDLE cycle
      start_miss(32'h400);
      for (int k = 0; k < 4; k++) begin
         check_val("held_addr", mem_addr, 32'h400 + 32'(k * 4));
         check_val("held_req", {31'b0, mem_req}, 32'h1);
         mem_ack   = 1'b1;
         mem_rdata = 32'hF0 + 32'(k);
         @(negedge clk);
      end
      mem_rdata = 32'hDEAD;
      check_val("held_req_drop", {31'b0, mem_req}, 32'h0);
      @(negedge clk);
      check_val("held_idle_req", {31'b0, mem_req}, 32'h0);
      mem_ack = 1'b0;
      $display("refill line=00000400 words=4 base=000000f0 (held ack)");
      expect_hit(32'h400, 32'hF0);
      expect_hit(32'h40C, 32'hF3);

      // A different index leaves index 0 intact
      start_miss(32'h14);
      serve_refill(32'h10, 32'h50, 1, 4, -1);
      expect_hit(32'h14, 32'h51);
      expect_hit(32'h1C, 32'h53);
      expect_hit(32'h404, 32'hF1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that sits between the fetch stage and the backing instruction memory.
- Services the fetch stage's PC request (PCF) and returns InstrF combinationally on a hit.
- On a miss it raises a stall, refills the whole line from backing memory over a req/ack handshake, then resumes.
- Its stall output is OR-ed into the hazard unit's StallF/StallD generation.

Parameters:
- INDEX_W, 4, number of index bits; the cache holds 2**INDEX_W lines.
- LINE_W, 2, log2 of the number of 32-bit words per line; default is 4 words (16 bytes).
- NOP_INSTR, 32'h00000013, value driven on InstrF while a miss is outstanding.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCF  input  32  fetch address from the fetch stage; byte address, bits [1:0] ignored.
- Invalidate  input  1  one-cycle pulse that clears all valid bits (fence.i).
- InstrF  output  32  instruction for PCF; valid when StallICache=0.
- StallICache  output  1  high while PCF misses or a refill is in progress.
- mem_req  output  1  word read request to backing memory.
- mem_addr  output  32  word-aligned backing-memory address.
- mem_ack  input  1  backing memory has returned mem_rdata this cycle.
- mem_rdata  input  32  read data, valid with mem_ack.

Behaviour:
- Address split: offset = PCF[LINE_W+1:2]; index = PCF[LINE_W+INDEX_W+1:LINE_W+2]; tag = PCF[31:LINE_W+INDEX_W+2].
- Storage per line: valid bit, tag, and 2**LINE_W data words. Data and tag arrays need no reset; only the valid bits are reset.
- Hit = valid[index] AND tag match. The hit path is combinational and has zero latency:
  - InstrF = data[index][offset].
  - StallICache = 0.
- Miss in IDLE:
  - StallICache = 1 in the same cycle (combinational).
  - InstrF = NOP_INSTR.
  - On the next edge the FSM enters REFILL and latches refill_tag and refill_index from PCF, and sets word_cnt = 0.
- FSM has two states, IDLE and REFILL. Reset state is IDLE.
- REFILL state:
  - mem_req = 1 and mem_addr = {refill_tag, refill_index, word_cnt, 2'b00}.
  - mem_addr is held stable while mem_req=1 and no ack has arrived.
  - On each mem_ack, write mem_rdata into data[refill_index][word_cnt] and increment word_cnt.
  - mem_req stays high across consecutive words, so back-to-back acks are allowed, one word per cycle.
  - StallICache = 1 and InstrF = NOP_INSTR throughout REFILL.
  - The refill always fetches words 0..2**LINE_W-1 in order (no critical-word-first).
- Last ack (word_cnt = 2**LINE_W-1):
  - Write tag[refill_index] = refill_tag and set valid[refill_index] = 1, unless an invalidate is pending.
  - Return to IDLE with mem_req = 0 on the following cycle.
  - word_cnt wraps to 0.
  - Minimum miss penalty with immediate acks: 1 cycle to enter REFILL, plus 2**LINE_W ack cycles, plus the hit cycle.
- mem_ack is ignored in IDLE.
- PCF is ignored during REFILL. The refill completes for the latched address, then PCF is looked up again in IDLE. If PCF changed, this may cause a fresh miss.
- Invalidate:
  - In IDLE, all valid bits clear at the edge. A lookup in the same cycle uses the pre-clear valid bits.
  - In REFILL, the invalidate is latched as inv_pending. When the refill completes, all valid bits clear and the refilled line is NOT marked valid; inv_pending then clears.
- Reset (asynchronous, may arrive mid-refill):
  - State = IDLE, all valid = 0, word_cnt = 0, inv_pending = 0, mem_req = 0.
  - A partially written line stays invalid.
- Output values after reset:
  - mem_req = 0 and mem_addr = 0.
  - StallICache follows the lookup; it is 1 for any PCF because all lines are invalid.
  - InstrF = NOP_INSTR.

Test Plan:
- Cold miss:
  - Stimulus: reset release, PCF=0x0000_0000; memory acks 3 cycles after each req with data 0xA0+word.
  - Required: StallICache=1 immediately; mem_addr sequence 0x0, 0x4, 0x8, 0xC.
  - Required: after the 4th ack plus 1 cycle, StallICache=0 and InstrF=0xA0.
- Hits after refill:
  - Stimulus: PCF steps 0x4, 0x8, 0xC.
  - Required: InstrF = 0xA1, 0xA2, 0xA3 in the same cycles; StallICache=0; mem_req stays 0.
- Conflict miss:
  - Stimulus: PCF=0x0000_0100 (same index 0, tag 1), immediate acks with data 0xB0+word.
  - Required: refill addresses 0x100..0x10C; then PCF=0x0 misses again and refetches 0xA0.
- Invalidate:
  - Stimulus: Invalidate pulse in IDLE with line 0 valid, then PCF=0x0.
  - Required: a miss with a new refill.
  - Stimulus: Invalidate pulsed during a refill.
  - Required: after completion, PCF at the same address still misses.
- Reset mid-refill:
  - Stimulus: assert rst after the 2nd ack of a refill.
  - Required: mem_req=0 asynchronously; state IDLE; the same PCF misses and restarts at word 0.
- Back-to-back acks plus held ack:
  - Stimulus: mem_ack held high for 4 consecutive cycles.
  - Required: exactly 4 words written, no extra write; mem_req=0 on the cycle after the last ack.
